// File: rtl/datapath_pkg.sv
// Load/store datapath types: access size, queue entry layout and LSQ FSM states.
package datapath_pkg;

  typedef enum logic [1:0] {
    LS_B = 2'd0,
    LS_H = 2'd1,
    LS_W = 2'd2
  } ls_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsq_state_t;

  // The destination tag travels alongside this struct in the queue word.
  typedef struct packed {
    logic [31:0] ea;
    logic [31:0] sdata;
    logic [3:0]  be;
    ls_size_t    size;
    logic        uns;
    logic        is_store;
    logic        fault;
  } lsq_entry_t;

endpackage

// File: rtl/isa_pkg.sv
// ISA-level types shared across the scalar pipeline.
package isa_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    LOAD      = 2'd1,
    STORE     = 2'd2,
    MEM_FENCE = 2'd3
  } mem_type_t;

endpackage

// File: rtl/lsq_fifo.sv
// Generic DEPTH x W synchronous FIFO with flush; pointers carry an extra wrap bit.
module lsq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (push && !full) r_wptr <= r_wptr + PTR_ONE;
      if (pop && !empty) r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !full && !flush) r_mem[r_wptr[AW-1:0]] <= wdata;
  end

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign rdata = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/fu_scalar_lsq.sv
// Scalar load/store unit: queued issue, one in-order dmem access at a time, tagged writeback.
// Define LS_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of forcing alignment.
module fu_scalar_lsq
  import isa_pkg::*;
  import datapath_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  mem_type_t        req_mem_type,
  input  ls_size_t         req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      rs1,
  input  logic [31:0]      rs2,
  input  logic [31:0]      imm,
  input  logic [TAG_W-1:0] req_tag,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic [31:0]      dmemaddr,
  output logic [31:0]      dmemstore,
  output logic [3:0]       dmem_be,
  input  logic             dhit_in,
  input  logic [31:0]      dmem_in,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [TAG_W-1:0] resp_tag,
  output logic [31:0]      resp_data,
  output logic             resp_is_store,
  output logic             resp_fault
);
  localparam int EW = $bits(lsq_entry_t);
  localparam int FW = TAG_W + EW;

  lsq_state_t       r_state, w_next;
  lsq_entry_t       r_act, w_enq, w_head;
  logic [TAG_W-1:0] r_act_tag, w_head_tag;
  logic [31:0]      r_ld_word, w_ea;
  logic [FW-1:0]    w_head_raw;
  logic             w_full, w_empty, w_push, w_pop;

  function automatic logic [3:0] byte_en(ls_size_t sz, logic [1:0] a);
    case (sz)
      LS_B:    return 4'b0001 << a;
      LS_H:    return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_store(ls_size_t sz, logic [1:0] a, logic [31:0] d);
    case (sz)
      LS_B:    return {24'b0, d[7:0]} << {a, 3'b000};
      LS_H:    return {16'b0, d[15:0]} << {a[1], 4'b0000};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_fmt(lsq_entry_t e, logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{e.ea[1:0], 3'b000} +: 8];
    h = e.ea[1] ? w[31:16] : w[15:0];
    case (e.size)
      LS_B:    return e.uns ? {24'b0, b} : {{24{b[7]}}, b};
      LS_H:    return e.uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

`ifdef LS_MISALIGN_TRAP_EN
  function automatic logic misaligned(ls_size_t sz, logic [1:0] a);
    return (sz == LS_H && a[0]) || (sz == LS_W && a != 2'b00);
  endfunction
`endif

  assign w_ea = rs1 + imm;

  always_comb begin
    w_enq.ea       = w_ea;
    w_enq.sdata    = lane_store(req_size, w_ea[1:0], rs2);
    w_enq.be       = byte_en(req_size, w_ea[1:0]);
    w_enq.size     = req_size;
    w_enq.uns      = req_unsigned;
    w_enq.is_store = (req_mem_type == STORE);
`ifdef LS_MISALIGN_TRAP_EN
    w_enq.fault    = misaligned(req_size, w_ea[1:0]);
`else
    w_enq.fault    = 1'b0;
`endif
  end

  assign req_ready  = !w_full && !flush;
  assign w_push     = req_valid && req_ready && (req_mem_type == LOAD || req_mem_type == STORE);
  // A flush cycle never pops, so the head cannot slip into the active slot as it is discarded.
  assign w_pop      = !w_empty && !flush &&
                      (r_state == IDLE || (r_state == RESP && resp_ready));
  assign w_head_tag = w_head_raw[FW-1 -: TAG_W];
  assign w_head     = lsq_entry_t'(w_head_raw[EW-1:0]);

  lsq_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
    .CLK   (CLK),
    .nRST  (nRST),
    .flush (flush),
    .push  (w_push),
    .pop   (w_pop),
    .wdata ({req_tag, w_enq}),
    .rdata (w_head_raw),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (w_pop) begin
      r_act     <= w_head;
      r_act_tag <= w_head_tag;
    end
    if (r_state == ACCESS && dhit_in) r_ld_word <= dmem_in;
  end

  always_comb begin
    w_next        = r_state;
    dmemREN       = 1'b0;
    dmemWEN       = 1'b0;
    dmemaddr      = '0;
    dmemstore     = '0;
    dmem_be       = '0;
    resp_valid    = 1'b0;
    resp_tag      = '0;
    resp_data     = '0;
    resp_is_store = 1'b0;
    resp_fault    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pop) w_next = w_head.fault ? RESP : ACCESS;
      end
      ACCESS: begin
        dmemREN   = !r_act.is_store && !dhit_in;
        dmemWEN   = r_act.is_store && !dhit_in;
        dmemaddr  = {r_act.ea[31:2], 2'b00};
        dmemstore = r_act.sdata;
        dmem_be   = r_act.be;
        if (dhit_in) w_next = RESP;
      end
      RESP: begin
        resp_valid    = 1'b1;
        resp_tag      = r_act_tag;
        resp_is_store = r_act.is_store;
        resp_data     = r_act.fault    ? r_act.ea :
                        r_act.is_store ? 32'h0    : load_fmt(r_act, r_ld_word);
`ifdef LS_MISALIGN_TRAP_EN
        resp_fault    = r_act.fault;
`endif
        if (resp_ready) w_next = w_pop ? (w_head.fault ? RESP : ACCESS) : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fu_scalar_lsq.sv
// Self-checking bench for fu_scalar_lsq: directed scenarios plus a randomized run against a queue model.
module tb_fu_scalar_lsq;
  import isa_pkg::*;
  import datapath_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  logic             CLK, nRST, flush, req_valid, req_ready, req_unsigned;
  mem_type_t        req_mem_type;
  ls_size_t         req_size;
  logic [31:0]      rs1, rs2, imm, dmemaddr, dmemstore, dmem_in, resp_data;
  logic [TAG_W-1:0] req_tag, resp_tag;
  logic             dmemREN, dmemWEN, dhit_in, resp_valid, resp_ready, resp_is_store, resp_fault;
  logic [3:0]       dmem_be;

  int checks = 0;
  int errors = 0;

  fu_scalar_lsq #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_mem_type(req_mem_type), .req_size(req_size), .req_unsigned(req_unsigned),
    .rs1(rs1), .rs2(rs2), .imm(imm), .req_tag(req_tag),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dmem_be(dmem_be), .dhit_in(dhit_in), .dmem_in(dmem_in),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_tag(resp_tag),
    .resp_data(resp_data), .resp_is_store(resp_is_store), .resp_fault(resp_fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] ea, rs2, word;
    ls_size_t size;
    logic uns, is_store, fault, done;
    logic [TAG_W-1:0] tag;
  } op_t;

  typedef struct {
    logic acc, strobe_idle, ren, wen, strobe_hit, rv, rs, rf, rv_after;
    logic [31:0] addr, st, rd;
    logic [3:0] be;
    logic [TAG_W-1:0] rt;
  } obs_t;

  // Reference model: byte-lane arithmetic straight from the access rules.
  function automatic logic [3:0] m_be(ls_size_t sz, logic [31:0] ea);
    case (sz)
      LS_B:    return 4'(1 << (ea % 4));
      LS_H:    return 4'(3 << (ea & 2));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_store(ls_size_t sz, logic [31:0] ea, logic [31:0] d);
    case (sz)
      LS_B:    return (d & 32'hFF) << (8 * (ea % 4));
      LS_H:    return (d & 32'hFFFF) << (8 * (ea & 2));
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(ls_size_t sz, logic [31:0] ea, logic uns, logic [31:0] w);
    logic [31:0] v;
    case (sz)
      LS_B: begin
        v = (w >> (8 * (ea % 4))) & 32'hFF;
        if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
      end
      LS_H: begin
        v = (w >> (8 * (ea & 2))) & 32'hFFFF;
        if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic m_fault(ls_size_t sz, logic [31:0] ea);
`ifdef LS_MISALIGN_TRAP_EN
    return (sz == LS_H && (ea % 2) != 0) || (sz == LS_W && (ea % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_req(input mem_type_t mt, input ls_size_t sz, input logic uns,
                           input logic [31:0] base, input logic [31:0] off,
                           input logic [31:0] d, input logic [TAG_W-1:0] t);
    req_valid = 1'b1; req_mem_type = mt; req_size = sz; req_unsigned = uns;
    rs1 = base; imm = off; rs2 = d; req_tag = t;
  endtask

  // Issues one op into an idle unit, completes dmem immediately and accepts the response.
  task automatic single_op(input mem_type_t mt, input ls_size_t sz, input logic uns,
                           input logic [31:0] base, input logic [31:0] off, input logic [31:0] d,
                           input logic [TAG_W-1:0] t, input logic [31:0] word, output obs_t o);
    step(); drive_req(mt, sz, uns, base, off, d, t); #1 o.acc = req_ready;
    step(); req_valid = 1'b0; #1 o.strobe_idle = dmemREN | dmemWEN;
    step(); #1;
    o.ren = dmemREN; o.wen = dmemWEN; o.addr = dmemaddr; o.be = dmem_be; o.st = dmemstore;
    dhit_in = 1'b1; dmem_in = word; #1 o.strobe_hit = dmemREN | dmemWEN;
    step(); dhit_in = 1'b0; resp_ready = 1'b1; #1;
    o.rv = resp_valid; o.rd = resp_data; o.rt = resp_tag; o.rs = resp_is_store; o.rf = resp_fault;
    step(); resp_ready = 1'b0; #1 o.rv_after = resp_valid;
  endtask

  task automatic test_reset();
    nRST = 1'b0; flush = 1'b0; req_valid = 1'b0; req_mem_type = MEM_NONE; req_size = LS_B;
    req_unsigned = 1'b0; rs1 = '0; rs2 = '0; imm = '0; req_tag = '0;
    dhit_in = 1'b0; dmem_in = '0; resp_ready = 1'b0;
    #12;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++;
    if ({dmemREN, dmemWEN, dmemaddr, dmemstore, dmem_be, resp_valid, resp_tag, resp_data,
         resp_is_store, resp_fault} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: REN=%b WEN=%b addr=%h st=%h be=%h rv=%b tag=%h data=%h st=%b f=%b want all 0",
               dmemREN, dmemWEN, dmemaddr, dmemstore, dmem_be, resp_valid, resp_tag, resp_data,
               resp_is_store, resp_fault);
    end
    @(negedge CLK) nRST = 1'b1;
  endtask

  task automatic test_word_load();
    obs_t o;
    single_op(LOAD, LS_W, 1'b0, 32'h100, 32'h4, 32'h0, 5'd3, 32'hDEADBEEF, o);
    checks++; if (o.acc !== 1'b1) begin errors++; $display("FAIL wl_accept: got %b want 1", o.acc); end
    checks++; if (o.strobe_idle !== 1'b0) begin errors++; $display("FAIL wl_idle_strobe: got %b want 0", o.strobe_idle); end
    checks++; if ({o.ren, o.wen} !== 2'b10) begin errors++; $display("FAIL wl_strobes: got %b want 10", {o.ren, o.wen}); end
    checks++; if (o.addr !== 32'h104) begin errors++; $display("FAIL wl_addr: got %h want 00000104", o.addr); end
    checks++; if (o.be !== 4'hF) begin errors++; $display("FAIL wl_be: got %h want f", o.be); end
    checks++; if (o.strobe_hit !== 1'b0) begin errors++; $display("FAIL wl_strobe_drop: got %b want 0", o.strobe_hit); end
    checks++; if (o.rv !== 1'b1) begin errors++; $display("FAIL wl_resp_valid: got %b want 1", o.rv); end
    checks++; if (o.rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wl_data: got %h want deadbeef", o.rd); end
    checks++; if ({o.rt, o.rs, o.rf} !== {5'd3, 1'b0, 1'b0}) begin errors++; $display("FAIL wl_tag_flags: got %h/%b/%b want 03/0/0", o.rt, o.rs, o.rf); end
    checks++; if (o.rv_after !== 1'b0) begin errors++; $display("FAIL wl_resp_clear: got %b want 0", o.rv_after); end
  endtask

  task automatic test_byte_load();
    obs_t o;
    single_op(LOAD, LS_B, 1'b0, 32'h100, 32'h3, 32'h0, 5'd4, 32'h8000_0000, o);
    checks++; if ({o.addr, o.be} !== {32'h100, 4'b1000}) begin errors++; $display("FAIL bl_addr_be: got %h/%b want 00000100/1000", o.addr, o.be); end
    checks++; if (o.rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL bl_signed: got %h want ffffff80", o.rd); end
    single_op(LOAD, LS_B, 1'b1, 32'h100, 32'h3, 32'h0, 5'd5, 32'h8000_0000, o);
    checks++; if (o.rd !== 32'h0000_0080) begin errors++; $display("FAIL bl_unsigned: got %h want 00000080", o.rd); end
    single_op(LOAD, LS_H, 1'b0, 32'h100, 32'h2, 32'h0, 5'd6, 32'h9ABC_1234, o);
    checks++; if ({o.be, o.rd} !== {4'b1100, 32'hFFFF_9ABC}) begin errors++; $display("FAIL hl_signed: got %b/%h want 1100/ffff9abc", o.be, o.rd); end
  endtask

  task automatic test_half_store();
    obs_t o;
    single_op(STORE, LS_H, 1'b0, 32'h20, 32'h2, 32'h1234, 5'd7, 32'hFFFF_FFFF, o);
    checks++; if ({o.ren, o.wen} !== 2'b01) begin errors++; $display("FAIL hs_strobes: got %b want 01", {o.ren, o.wen}); end
    checks++; if ({o.addr, o.be} !== {32'h20, 4'b1100}) begin errors++; $display("FAIL hs_addr_be: got %h/%b want 00000020/1100", o.addr, o.be); end
    checks++; if (o.st[31:16] !== 16'h1234) begin errors++; $display("FAIL hs_store_data: got %h want 1234", o.st[31:16]); end
    checks++; if ({o.rv, o.rs, o.rd, o.rt} !== {1'b1, 1'b1, 32'h0, 5'd7}) begin errors++; $display("FAIL hs_resp: got v=%b st=%b d=%h t=%h want 1/1/0/07", o.rv, o.rs, o.rd, o.rt); end
  endtask

  task automatic test_misalign();
    logic strobe_seen, got;
    logic [31:0] d;
    logic f;
    strobe_seen = 1'b0; got = 1'b0; d = '0; f = 1'b0;
    step(); drive_req(LOAD, LS_W, 1'b0, 32'h100, 32'h1, 32'h0, 5'd9);
    step(); req_valid = 1'b0; resp_ready = 1'b1;
    for (int c = 0; c < 10 && !got; c++) begin
      #1;
      if (dmemREN | dmemWEN) begin strobe_seen = 1'b1; dhit_in = 1'b1; dmem_in = 32'h1122_3344; end
      if (resp_valid) begin got = 1'b1; d = resp_data; f = resp_fault; end
      step(); dhit_in = 1'b0;
    end
    resp_ready = 1'b0;
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL ma_resp_timeout: got %b want 1", got); end
`ifdef LS_MISALIGN_TRAP_EN
    checks++; if (strobe_seen !== 1'b0) begin errors++; $display("FAIL ma_no_strobe: got %b want 0", strobe_seen); end
    checks++; if ({f, d} !== {1'b1, 32'h101}) begin errors++; $display("FAIL ma_fault: got %b/%h want 1/00000101", f, d); end
`else
    checks++; if (strobe_seen !== 1'b1) begin errors++; $display("FAIL ma_strobe: got %b want 1", strobe_seen); end
    checks++; if ({f, d} !== {1'b0, 32'h1122_3344}) begin errors++; $display("FAIL ma_aligned: got %b/%h want 0/11223344", f, d); end
`endif
  endtask

  task automatic test_fill();
    int acc, got;
    logic order_ok;
    acc = 0; got = 0; order_ok = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      step(); drive_req(LOAD, LS_W, 1'b0, 32'h200, 32'(4 * acc), 32'h0, TAG_W'(acc));
      #1 if (req_ready) acc++;
    end
    step(); req_valid = 1'b0; #1;
    checks++; if (acc !== DEPTH + 1) begin errors++; $display("FAIL fill_accepts: got %0d want %0d", acc, DEPTH + 1); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_low: got %b want 0", req_ready); end
    resp_ready = 1'b1;
    for (int c = 0; c < 100 && got < DEPTH + 1; c++) begin
      step(); dhit_in = 1'b0; #1;
      if (dmemREN) begin dhit_in = 1'b1; dmem_in = $urandom; end
      if (resp_valid) begin
        if (resp_tag !== TAG_W'(got)) order_ok = 1'b0;
        got++;
      end
    end
    step(); dhit_in = 1'b0; resp_ready = 1'b0;
    checks++; if (got !== DEPTH + 1) begin errors++; $display("FAIL fill_drain: got %0d responses want %0d", got, DEPTH + 1); end
    checks++; if (order_ok !== 1'b1) begin errors++; $display("FAIL fill_order: got out-of-order=%b want 0", !order_ok); end
  endtask

  task automatic test_flush();
    int got, acc, strobes;
    logic [TAG_W-1:0] first;
    got = 0; acc = 0; strobes = 0; first = '0;
    for (int i = 0; i < 4; i++) begin
      step(); drive_req(LOAD, LS_W, 1'b0, 32'h300, 32'(4 * i), 32'h0, TAG_W'(10 + i));
      #1 if (req_ready) acc++;
    end
    step(); drive_req(STORE, LS_W, 1'b0, 32'h400, 32'h0, 32'h55, 5'd14); flush = 1'b1; #1;
    checks++; if ({acc, dmemREN} !== {32'd4, 1'b1}) begin errors++; $display("FAIL flush_setup: got acc=%0d REN=%b want 4/1", acc, dmemREN); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", req_ready); end
    step(); flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      dhit_in = 1'b0; #1;
      if (dmemREN | dmemWEN) begin strobes++; dhit_in = 1'b1; dmem_in = $urandom; end
      if (resp_valid) begin if (got == 0) first = resp_tag; got++; end
      step();
    end
    dhit_in = 1'b0; resp_ready = 1'b0; #1;
    checks++; if ({got, strobes} !== {32'd1, 32'd1}) begin errors++; $display("FAIL flush_count: got resp=%0d acc=%0d want 1/1", got, strobes); end
    checks++; if (first !== 5'd10) begin errors++; $display("FAIL flush_tag: got %0d want 10", first); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_empty_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_back_to_back();
    int issued, got;
    int at[4];
    issued = 0; got = 0;
    resp_ready = 1'b1;
    for (int c = 0; c < 60 && got < 4; c++) begin
      step(); dhit_in = 1'b0;
      if (issued < 4) drive_req(LOAD, LS_W, 1'b0, 32'h500, 32'(4 * issued), 32'h0, TAG_W'(20 + issued));
      else req_valid = 1'b0;
      #1;
      if (req_valid && req_ready) issued++;
      if (dmemREN) begin dhit_in = 1'b1; dmem_in = $urandom; end
      if (resp_valid) begin at[got] = c; got++; end
    end
    step(); dhit_in = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    checks++; if (got !== 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", got); end
    else begin
      checks++;
      if (at[3] - at[0] !== 6 || at[1] - at[0] !== 2) begin
        errors++; $display("FAIL b2b_spacing: got %0d/%0d cycles want 2/6", at[1] - at[0], at[3] - at[0]);
      end
    end
  endtask

  task automatic test_random();
    op_t q[$];
    op_t n, h;
    int idx;
    logic [31:0] exp_data;
    for (int c = 0; c < 1200; c++) begin
      step(); dhit_in = 1'b0;
      resp_ready = ($urandom % 4) != 0;
      if (c < 700 && ($urandom % 3) != 0)
        drive_req(mem_type_t'($urandom_range(0, 3)), ls_size_t'($urandom_range(0, 2)),
                  1'($urandom), $urandom, 32'($urandom_range(0, 63)), $urandom, TAG_W'($urandom));
      else req_valid = 1'b0;
      #1;
      if (req_valid && req_ready && (req_mem_type == LOAD || req_mem_type == STORE)) begin
        n.ea = rs1 + imm; n.rs2 = rs2; n.word = '0; n.size = req_size; n.uns = req_unsigned;
        n.is_store = (req_mem_type == STORE); n.fault = m_fault(req_size, rs1 + imm);
        n.done = 1'b0; n.tag = req_tag;
        q.push_back(n);
      end
      if (dmemREN | dmemWEN) begin
        idx = -1;
        foreach (q[k]) if (idx < 0 && !q[k].fault && !q[k].done) idx = k;
        checks++;
        if (idx < 0) begin errors++; $display("FAIL rnd_access: unexpected access addr=%h", dmemaddr); end
        else begin
          h = q[idx];
          if ({dmemREN, dmemWEN, dmemaddr, dmem_be, dmemWEN ? dmemstore : 32'h0} !==
              {!h.is_store, h.is_store, h.ea & 32'hFFFF_FFFC, m_be(h.size, h.ea),
               h.is_store ? m_store(h.size, h.ea, h.rs2) : 32'h0}) begin
            errors++;
            $display("FAIL rnd_access: got R=%b W=%b a=%h be=%h st=%h want ea=%h sz=%0d store=%b",
                     dmemREN, dmemWEN, dmemaddr, dmem_be, dmemstore, h.ea, h.size, h.is_store);
          end
          if (($urandom % 3) != 0) begin
            dhit_in = 1'b1; dmem_in = $urandom;
            h.done = 1'b1; h.word = dmem_in; q[idx] = h;
          end
        end
      end
      if (resp_valid && resp_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL rnd_resp: unexpected response tag=%h", resp_tag); end
        else begin
          h = q.pop_front();
          exp_data = h.fault ? h.ea : h.is_store ? 32'h0 : m_load(h.size, h.ea, h.uns, h.word);
          if (!(h.done || h.fault) ||
              {resp_tag, resp_data, resp_is_store, resp_fault} !== {h.tag, exp_data, h.is_store, h.fault}) begin
            errors++;
            $display("FAIL rnd_resp: got t=%h d=%h s=%b f=%b want t=%h d=%h s=%b f=%b done=%b",
                     resp_tag, resp_data, resp_is_store, resp_fault, h.tag, exp_data, h.is_store, h.fault, h.done);
          end
        end
      end
    end
    step(); dhit_in = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL rnd_drain: got %0d ops outstanding want 0", q.size()); end
  endtask

  task automatic test_reset_mid_access();
    int strobes, got;
    strobes = 0; got = 0;
    step(); drive_req(LOAD, LS_W, 1'b0, 32'h600, 32'h0, 32'h0, 5'd1);
    step(); drive_req(STORE, LS_W, 1'b0, 32'h604, 32'h0, 32'h77, 5'd2);
    step(); req_valid = 1'b0; #1;
    checks++; if (dmemREN !== 1'b1) begin errors++; $display("FAIL rst_mid_setup: got REN=%b want 1", dmemREN); end
    #1 nRST = 1'b0; #1;
    checks++; if ({dmemREN, dmemWEN, resp_valid} !== 3'b000) begin errors++; $display("FAIL rst_mid_strobe: got %b want 000", {dmemREN, dmemWEN, resp_valid}); end
    step(); nRST = 1'b1; resp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step(); dhit_in = 1'b0; #1;
      if (dmemREN | dmemWEN) begin strobes++; dhit_in = 1'b1; end
      if (resp_valid) got++;
    end
    dhit_in = 1'b0; resp_ready = 1'b0;
    checks++; if ({strobes, got, req_ready} !== {32'd0, 32'd0, 1'b1}) begin errors++; $display("FAIL rst_mid_lost: got acc=%0d resp=%0d rdy=%b want 0/0/1", strobes, got, req_ready); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misalign();
    test_fill();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
